pattern_sequencer: RTL

- Control block that drives the 2-bit pattern select of the test pattern generator.
- Advances the pattern on a debounced button press or, in auto mode, after a programmable number of frames.
- Every select change is committed only at a frame boundary, so no frame ever shows two patterns.
- Sits in the pixel clock domain between board I/O and the pattern generator's select input.

---
 rtl/pattern_pkg.sv | 30 +++
 rtl/button_debouncer.sv | 45 ++++
 rtl/pattern_sequencer.sv | 95 +++++++++
 3 files changed

// File: rtl/pattern_pkg.sv
// Shared types for the test pattern sequencer.
// Pattern select encoding, sequencer states and frame counter width.
package pattern_pkg;

    typedef enum logic [1:0] {
        PAT_CYAN      = 2'd0,
        PAT_CROSSHAIR = 2'd1,
        PAT_HGRAD     = 2'd2,
        PAT_COLOR     = 2'd3
    } pattern_t;

    typedef enum logic {
        S_HOLD    = 1'b0,
        S_PENDING = 1'b1
    } seq_state_t;

    localparam int FRAME_CNT_W = 12;

    // Step to the next select, wrapping at the last configured pattern.
    function automatic pattern_t next_pattern(
        input pattern_t    cur,
        input int unsigned num
    );
        if (32'(cur) + 32'd1 >= num) begin
            return PAT_CYAN;
        end
        return pattern_t'(cur + 2'd1);
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronises and debounces a raw pushbutton.
// Emits the stable level and a one-cycle pulse on each accepted press.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 371250
) (
    input  logic clk_pixel,
    input  logic rst_in,
    input  logic btn_in,
    output logic level,
    output logic press
);

    localparam int unsigned CNT_W =
        (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_pixel or posedge rst_in) begin
        if (rst_in) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
            press <= 1'b0;
            // Count consecutive cycles the sample disagrees with the level.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                cnt   <= '0;
                level <= sync2;
                press <= sync2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pattern_sequencer.sv
// Drives the pattern generator select from button presses or frame timing.
// Select changes are only committed on a frame boundary.
module pattern_sequencer
    import pattern_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES    = 371250,
    parameter int unsigned FRAMES_PER_PATTERN = 120,
    parameter int unsigned NUM_PATTERNS       = 4
) (
    input  logic       clk_pixel,
    input  logic       rst_in,
    input  logic       btn_in,
    input  logic       auto_en_in,
    input  logic       new_frame_in,
    output logic [1:0] sel_out,
    output logic       pending_out,
    output logic       advance_out
);

    localparam logic [FRAME_CNT_W-1:0] FRAME_LAST =
        FRAME_CNT_W'(FRAMES_PER_PATTERN - 1);

    seq_state_t             state;
    seq_state_t             state_nx;
    pattern_t               sel;
    pattern_t               sel_nx;
    logic                   adv_nx;
    logic [FRAME_CNT_W-1:0] fcnt;
    logic [FRAME_CNT_W-1:0] fcnt_nx;
    logic                   btn_level;
    logic                   btn_press;
    logic                   btn_req;
    logic                   auto_req;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk_pixel(clk_pixel),
        .rst_in   (rst_in),
        .btn_in   (btn_in),
        .level    (btn_level),
        .press    (btn_press)
    );

    // A press pulse always coincides with the high debounced level.
    assign btn_req = btn_press && btn_level;

    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        adv_nx   = 1'b0;
        fcnt_nx  = fcnt;
        auto_req = auto_en_in && new_frame_in
                && (state == S_HOLD) && (fcnt == FRAME_LAST);
        unique case (state)
            S_HOLD: begin
                if (auto_en_in && new_frame_in) begin
                    fcnt_nx = auto_req ? '0 : fcnt + FRAME_CNT_W'(1);
                end
                if (btn_req || auto_req) begin
                    state_nx = S_PENDING;
                end
            end
            S_PENDING: begin
                if (new_frame_in) begin
                    state_nx = S_HOLD;
                    sel_nx   = next_pattern(sel, NUM_PATTERNS);
                    adv_nx   = 1'b1;
                    fcnt_nx  = '0;
                end
            end
        endcase
        if (!auto_en_in) begin
            fcnt_nx = '0;
        end
    end

    always_ff @(posedge clk_pixel or posedge rst_in) begin
        if (rst_in) begin
            state       <= S_HOLD;
            sel         <= PAT_CYAN;
            advance_out <= 1'b0;
            fcnt        <= '0;
        end else begin
            state       <= state_nx;
            sel         <= sel_nx;
            advance_out <= adv_nx;
            fcnt        <= fcnt_nx;
        end
    end

    assign sel_out     = sel;
    assign pending_out = (state == S_PENDING);

endmodule
